// File: rtl/stpwtch_pkg.sv
// stpwtch_pkg: shared FSM state type and BCD digit limits for the stopwatch controller
package stpwtch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DEC_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEXT_MAX = 4'd5;
endpackage

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit: one cascadable BCD counter digit that wraps at MAX and reports a carry
module bcd_digit
  import stpwtch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DEC_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);
  assign carry = inc && q == MAX;
  // digit register: clear dominates, increment wraps to zero past MAX
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == MAX) ? '0 : q + 1'b1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear FSM, 1/100 s prescaler and SS.hh BCD count; lap freeze under STPWTCH_LAP_EN
module stopwatch_ctrl
  import stpwtch_pkg::*;
#(
  parameter int PRESCALE = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clr,
`ifdef STPWTCH_LAP_EN
  input  logic        lap,
  output logic        lap_frozen,
`endif
  output logic [15:0] digits,
  output logic        running,
  output logic        tick,
  output logic        ovfl
);
  localparam int PW = $clog2(PRESCALE);
  state_t state, state_nx;
  logic [PW-1:0] psc;
  logic [15:0] live;
  logic [3:0] c;
  logic clear_all;
  assign clear_all = state == PAUSE && clr;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: clr only acts in PAUSE and beats a coincident start_stop
  always_comb begin
    state_nx = clear_all ? IDLE : start_stop ? ((state == RUN) ? PAUSE : RUN) : state;
  end
  // prescaler advances only in RUN, holds in PAUSE so resume finishes the partial period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) psc <= '0;
    else if (clear_all) psc <= '0;
    else if (state == RUN) psc <= tick ? '0 : psc + 1'b1;
  bcd_digit #(.MAX(DEC_MAX)) u_hund (
    .clk(clk), .rst_n(rst_n), .clr(clear_all), .inc(tick), .q(live[3:0]), .carry(c[0])
  );
  bcd_digit #(.MAX(DEC_MAX)) u_tenth (
    .clk(clk), .rst_n(rst_n), .clr(clear_all), .inc(c[0]), .q(live[7:4]), .carry(c[1])
  );
  bcd_digit #(.MAX(DEC_MAX)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(clear_all), .inc(c[1]), .q(live[11:8]), .carry(c[2])
  );
  bcd_digit #(.MAX(SEXT_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(clear_all), .inc(c[2]), .q(live[15:12]), .carry(c[3])
  );
  // sticky overflow flag set when 59.99 wraps to 00.00
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovfl <= 1'b0;
    else if (clear_all) ovfl <= 1'b0;
    else if (c[3]) ovfl <= 1'b1;
`ifdef STPWTCH_LAP_EN
  logic [15:0] snap;
  logic frozen;
  // lap snapshot: toggled by lap while running, released when leaving RUN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snap <= '0;
      frozen <= 1'b0;
    end else if (clear_all) begin
      snap <= '0;
      frozen <= 1'b0;
    end else if (state == RUN && start_stop) frozen <= 1'b0;
    else if (state == RUN && lap) begin
      frozen <= !frozen;
      if (!frozen) snap <= live;
    end
`endif
  // outputs decoded from registers
  always_comb begin
    running = state == RUN;
    tick = running && psc == PW'(PRESCALE - 1);
`ifdef STPWTCH_LAP_EN
    lap_frozen = frozen;
    digits = frozen ? snap : live;
`else
    digits = live;
`endif
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table, corner sequences and randomized model check of stopwatch_ctrl
module tb_stopwatch_ctrl;
  localparam int P = 4;
  logic clk = 1'b0, rst_n = 1'b0, start_stop = 1'b0, clr = 1'b0;
  logic [15:0] digits;
  logic running, tick, ovfl;
`ifdef STPWTCH_LAP_EN
  logic lap = 1'b0, lap_frozen;
`endif
  int total = 0, bad = 0;
  typedef struct {
    logic ss;
    logic cl;
    int n;
    logic [15:0] d;
    logic run;
    logic tk;
    logic ov;
  } vec_t;
  vec_t tbl[11];
  int cs, ph;
  bit m_run, m_started, m_ov;
`ifdef STPWTCH_LAP_EN
  bit m_fz;
  logic [15:0] m_snap;
`endif

  stopwatch_ctrl #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clr(clr),
`ifdef STPWTCH_LAP_EN
    .lap(lap), .lap_frozen(lap_frozen),
`endif
    .digits(digits), .running(running), .tick(tick), .ovfl(ovfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic c, input int n);
    start_stop = s;
    clr = c;
    @(posedge clk);
    #1 start_stop = 1'b0;
    clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int sec;
    sec = v / 100;
    return {4'(sec / 10), 4'(sec % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit m_tick();
    return m_run && ph == P - 1;
  endfunction

  task automatic m_edge(input bit s, input bit c);
    bit tk;
    tk = m_tick();
`ifdef STPWTCH_LAP_EN
    if (m_run) begin
      if (s) m_fz = 1'b0;
      else if (lap) begin
        if (!m_fz) m_snap = to_bcd(cs);
        m_fz = !m_fz;
      end
    end
`endif
    if (m_run) begin
      if (tk) begin
        if (cs == 5999) m_ov = 1'b1;
        cs = (cs + 1) % 6000;
      end
      ph = (ph + 1) % P;
      if (s) m_run = 1'b0;
    end else if (m_started) begin
      if (c) begin
        m_started = 1'b0;
        cs = 0;
        ph = 0;
        m_ov = 1'b0;
`ifdef STPWTCH_LAP_EN
        m_fz = 1'b0;
        m_snap = '0;
`endif
      end else if (s) m_run = 1'b1;
    end else if (s) begin
      m_run = 1'b1;
      m_started = 1'b1;
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 40, 16'h0010, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3,  16'h0011, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5,  16'h0011, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2,  16'h0011, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 0,  16'h0012, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1,  16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2,  16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3,  16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 7,  16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2,  16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1,  16'h0000, 1'b0, 1'b0, 1'b0};
    #12 rst_n = 1'b1;
    #1;
    chk("reset_digits", digits, 16'h0000);
    chk("reset_running", 16'(running), 16'h0);
    chk("reset_tick", 16'(tick), 16'h0);
    chk("reset_ovfl", 16'(ovfl), 16'h0);
`ifdef STPWTCH_LAP_EN
    chk("reset_lap_frozen", 16'(lap_frozen), 16'h0);
`endif
    for (int i = 0; i < 11; i++) begin
      pulse(tbl[i].ss, tbl[i].cl, tbl[i].n);
      chk($sformatf("vec%0d_digits", i), digits, tbl[i].d);
      chk($sformatf("vec%0d_running", i), 16'(running), 16'(tbl[i].run));
      chk($sformatf("vec%0d_tick", i), 16'(tick), 16'(tbl[i].tk));
      chk($sformatf("vec%0d_ovfl", i), 16'(ovfl), 16'(tbl[i].ov));
    end
`ifdef STPWTCH_LAP_EN
    pulse(1'b1, 1'b0, 48);
    chk("lap_pre_digits", digits, 16'h0012);
    lap = 1'b1;
    @(posedge clk);
    #1 lap = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("lap_frozen_digits", digits, 16'h0012);
    chk("lap_frozen_flag", 16'(lap_frozen), 16'h1);
    chk("lap_frozen_running", 16'(running), 16'h1);
    lap = 1'b1;
    @(posedge clk);
    #1 lap = 1'b0;
    chk("lap_release_digits", digits, 16'h0014);
    chk("lap_release_flag", 16'(lap_frozen), 16'h0);
    pulse(1'b1, 1'b0, 0);
    pulse(1'b0, 1'b1, 0);
    chk("lap_cleared_digits", digits, 16'h0000);
`endif
    pulse(1'b1, 1'b0, 23996);
    chk("ovf_pre_digits", digits, 16'h5999);
    chk("ovf_pre_flag", 16'(ovfl), 16'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_wrap_digits", digits, 16'h0000);
    chk("ovf_wrap_flag", 16'(ovfl), 16'h1);
    pulse(1'b1, 1'b0, 0);
    chk("ovf_paused_flag", 16'(ovfl), 16'h1);
    chk("ovf_paused_running", 16'(running), 16'h0);
    pulse(1'b0, 1'b1, 0);
    chk("ovf_clr_flag", 16'(ovfl), 16'h0);
    chk("ovf_clr_digits", digits, 16'h0000);
    pulse(1'b1, 1'b0, 10);
    chk("arst_pre_digits", digits, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digits", digits, 16'h0000);
    chk("arst_running", 16'(running), 16'h0);
    chk("arst_tick", 16'(tick), 16'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_after_digits", digits, 16'h0000);
    chk("arst_after_running", 16'(running), 16'h0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cs = 0;
    ph = 0;
    m_run = 1'b0;
    m_started = 1'b0;
    m_ov = 1'b0;
`ifdef STPWTCH_LAP_EN
    m_fz = 1'b0;
    m_snap = '0;
`endif
    for (int i = 0; i < 4000; i++) begin
      bit s, c;
      logic [15:0] exp_d;
      exp_d = to_bcd(cs);
`ifdef STPWTCH_LAP_EN
      if (m_fz) exp_d = m_snap;
      chk("rnd_lap_frozen", 16'(lap_frozen), 16'(m_fz));
`endif
      chk("rnd_digits", digits, exp_d);
      chk("rnd_running", 16'(running), 16'(m_run));
      chk("rnd_tick", 16'(tick), 16'(m_tick()));
      chk("rnd_ovfl", 16'(ovfl), 16'(m_ov));
      s = $urandom_range(0, 24) == 0;
      c = $urandom_range(0, 19) == 0;
      start_stop = s;
      clr = c;
`ifdef STPWTCH_LAP_EN
      lap = $urandom_range(0, 29) == 0;
`endif
      @(posedge clk);
      m_edge(s, c);
      #1 start_stop = 1'b0;
      clr = 1'b0;
`ifdef STPWTCH_LAP_EN
      lap = 1'b0;
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
